// File: rtl/csr_pkg.sv
// Shared CSR types: operations, addresses, privilege, mstatus bit positions,
// interrupt/exception codes and the trap sequencer state encoding.
package csr_pkg;

  localparam int Xlen              = 64;
  localparam int CauseInterruptBit = Xlen - 1;

  typedef enum logic [2:0] {
    CsrNone,
    CsrAccess,
    CsrEcall,
    CsrMret,
    CsrSret,
    CsrIllegalInstruction
  } csr_op_t;

  typedef enum logic [1:0] {
    User       = 2'b00,
    Supervisor = 2'b01,
    Machine    = 2'b11
  } privilege_mode_t;

  typedef enum logic [11:0] {
    Sstatus = 12'h100,
    Sepc    = 12'h141,
    Scause  = 12'h142,
    Stval   = 12'h143,
    Mstatus = 12'h300,
    Mepc    = 12'h341,
    Mcause  = 12'h342,
    Mtval   = 12'h343
  } csr_addr_t;

  typedef enum logic [3:0] {
    StatusSie  = 4'd1,
    StatusMie  = 4'd3,
    StatusSpie = 4'd5,
    StatusMpie = 4'd7,
    StatusSpp  = 4'd8,
    StatusMpp  = 4'd11
  } status_t;

  localparam int MstatusSie  = int'(StatusSie);
  localparam int MstatusMie  = int'(StatusMie);
  localparam int MstatusSpie = int'(StatusSpie);
  localparam int MstatusMpie = int'(StatusMpie);
  localparam int MstatusSpp  = int'(StatusSpp);
  localparam int MstatusMpp  = int'(StatusMpp);  // two bits: [12:11]

  typedef enum logic [3:0] {
    IrqSsi = 4'd1,
    IrqMsi = 4'd3,
    IrqSti = 4'd5,
    IrqMti = 4'd7,
    IrqSei = 4'd9,
    IrqMei = 4'd11
  } interrupt_t;

  typedef enum logic [3:0] {
    ExcIllegalInstr = 4'd2,
    ExcEcallU       = 4'd8,
    ExcEcallS       = 4'd9,
    ExcEcallM       = 4'd11
  } exception_t;

  // Highest priority first.
  localparam interrupt_t IrqPriority [6] = '{IrqMei, IrqMsi, IrqMti, IrqSei, IrqSsi, IrqSti};

  typedef enum logic [2:0] {
    SeqIdle,
    SeqEpc,
    SeqCause,
    SeqTval,
    SeqStatus,
    SeqDone
  } seq_state_t;

endpackage

// File: rtl/csr_irq_select.sv
// Combinational pick of the highest-priority interrupt that is pending, enabled
// and allowed to trap at the current privilege; reports its code and target mode.
module csr_irq_select
  import csr_pkg::*;
(
  input  logic [11:0]     pending,
  input  logic [11:0]     enable,
  input  logic [11:0]     deleg,
  input  privilege_mode_t priv,
  input  logic            mstatus_mie,
  input  logic            mstatus_sie,
  output logic            valid,
  output interrupt_t      code,
  output privilege_mode_t target
);

  logic [11:0] active;
  logic        m_taken;
  logic        s_taken;

  always_comb begin
    valid   = 1'b0;
    code    = IrqMei;
    target  = Machine;
    active  = pending & enable;
    m_taken = (priv != Machine) || mstatus_mie;
    s_taken = (priv == User) || ((priv == Supervisor) && mstatus_sie);
    // Walk lowest to highest so the highest takeable interrupt is written last.
    for (int i = 5; i >= 0; i--) begin
      if (active[IrqPriority[i]] && (deleg[IrqPriority[i]] ? s_taken : m_taken)) begin
        valid  = 1'b1;
        code   = IrqPriority[i];
        target = deleg[IrqPriority[i]] ? Supervisor : Machine;
      end
    end
  end

endmodule

// File: rtl/csr_trap_sequencer.sv
// Sequences trap entry (4 CSR writes + redirect) and MRET/SRET (1 write + redirect); core stalls on busy.
// Optional CSR_VECTORED_TRAP_EN: vectored xtvec mode sends interrupts to base + 4*code.
module csr_trap_sequencer
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            instr_valid,
  input  csr_op_t         csr_op,
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mip,
  input  logic [XLEN-1:0] mideleg,
  input  logic [XLEN-1:0] medeleg,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] sepc,
  output logic            csr_we,
  output csr_addr_t       csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            busy,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output privilege_mode_t privilege_mode
);

  seq_state_t      state_q, state_n;
  privilege_mode_t priv_q, npriv_q, npriv_n, irq_target;
  interrupt_t      irq_code;
  logic            irq_vld;

  logic            take, is_ret, is_irq, to_s, ill_ret;
  logic [3:0]      code;
  logic [XLEN-1:0] tval_n, status_n, rpc_n, tvec, cause_n;

  logic            to_s_q;
  logic [XLEN-1:0] epc_q, cause_q, tval_q, status_q, rpc_q;

  logic            unused_bits;
  assign unused_bits = ^{mip[XLEN-1:12], mie[XLEN-1:12], mideleg[XLEN-1:12],
                         medeleg[XLEN-1:16], tvec[1:0]};

  csr_irq_select u_irq_select (
    .pending     (mip[11:0]),
    .enable      (mie[11:0]),
    .deleg       (mideleg[11:0]),
    .priv        (priv_q),
    .mstatus_mie (mstatus[MstatusMie]),
    .mstatus_sie (mstatus[MstatusSie]),
    .valid       (irq_vld),
    .code        (irq_code),
    .target      (irq_target)
  );

  // Decision and every value the sequence needs, evaluated against current inputs.
  always_comb begin
    take     = 1'b0;
    is_ret   = 1'b0;
    is_irq   = 1'b0;
    to_s     = 1'b0;
    code     = 4'd0;
    tval_n   = '0;
    status_n = mstatus;
    rpc_n    = '0;
    tvec     = mtvec;
    npriv_n  = Machine;
    ill_ret  = ((csr_op == CsrMret) && (priv_q != Machine)) ||
               ((csr_op == CsrSret) && (priv_q == User));

    if (ill_ret || (csr_op == CsrIllegalInstruction)) begin
      take   = 1'b1;
      code   = ExcIllegalInstr;
      tval_n = XLEN'(instr);
    end else if (csr_op == CsrEcall) begin
      take = 1'b1;
      code = (priv_q == User) ? ExcEcallU : (priv_q == Supervisor) ? ExcEcallS : ExcEcallM;
    end else if (irq_vld) begin
      take   = 1'b1;
      is_irq = 1'b1;
      code   = irq_code;
    end else if (csr_op == CsrMret) begin
      is_ret                       = 1'b1;
      status_n[MstatusMie]         = mstatus[MstatusMpie];
      status_n[MstatusMpie]        = 1'b1;
      status_n[MstatusMpp +: 2]    = User;
      npriv_n                      = privilege_mode_t'(mstatus[MstatusMpp +: 2]);
      rpc_n                        = mepc;
    end else if (csr_op == CsrSret) begin
      is_ret                = 1'b1;
      to_s                  = 1'b1;
      status_n[MstatusSie]  = mstatus[MstatusSpie];
      status_n[MstatusSpie] = 1'b1;
      status_n[MstatusSpp]  = 1'b0;
      npriv_n               = mstatus[MstatusSpp] ? Supervisor : User;
      rpc_n                 = sepc;
    end

    if (take) begin
      to_s = is_irq ? (irq_target == Supervisor) : (medeleg[code] && (priv_q != Machine));
      if (to_s) begin
        status_n[MstatusSpie] = mstatus[MstatusSie];
        status_n[MstatusSie]  = 1'b0;
        status_n[MstatusSpp]  = priv_q[0];
      end else begin
        status_n[MstatusMpie]     = mstatus[MstatusMie];
        status_n[MstatusMie]      = 1'b0;
        status_n[MstatusMpp +: 2] = priv_q;
      end
      npriv_n = to_s ? Supervisor : Machine;
      tvec    = to_s ? stvec : mtvec;
      rpc_n   = {tvec[XLEN-1:2], 2'b00};
`ifdef CSR_VECTORED_TRAP_EN
      if (is_irq && (tvec[1:0] == 2'b01)) rpc_n = rpc_n + XLEN'({code, 2'b00});
`endif
    end

    cause_n             = XLEN'(code);
    cause_n[XLEN-1]     = is_irq;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= SeqIdle;
      priv_q   <= Machine;
      npriv_q  <= Machine;
      to_s_q   <= 1'b0;
      epc_q    <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      status_q <= '0;
      rpc_q    <= '0;
    end else begin
      state_q <= state_n;
      if ((state_q == SeqIdle) && instr_valid && (take || is_ret)) begin
        npriv_q  <= npriv_n;
        to_s_q   <= to_s;
        epc_q    <= pc;
        cause_q  <= cause_n;
        tval_q   <= tval_n;
        status_q <= status_n;
        rpc_q    <= rpc_n;
      end
      if (state_q == SeqDone) priv_q <= npriv_q;
    end
  end

  always_comb begin
    state_n   = state_q;
    csr_we    = 1'b0;
    csr_waddr = Mstatus;
    csr_wdata = '0;
    redirect  = 1'b0;
    case (state_q)
      SeqIdle: begin
        if (instr_valid && take)        state_n = SeqEpc;
        else if (instr_valid && is_ret) state_n = SeqStatus;
      end
      SeqEpc: begin
        csr_we    = 1'b1;
        csr_waddr = to_s_q ? Sepc : Mepc;
        csr_wdata = epc_q;
        state_n   = SeqCause;
      end
      SeqCause: begin
        csr_we    = 1'b1;
        csr_waddr = to_s_q ? Scause : Mcause;
        csr_wdata = cause_q;
        state_n   = SeqTval;
      end
      SeqTval: begin
        csr_we    = 1'b1;
        csr_waddr = to_s_q ? Stval : Mtval;
        csr_wdata = tval_q;
        state_n   = SeqStatus;
      end
      SeqStatus: begin
        csr_we    = 1'b1;
        csr_waddr = to_s_q ? Sstatus : Mstatus;
        csr_wdata = status_q;
        state_n   = SeqDone;
      end
      SeqDone: begin
        redirect = 1'b1;
        state_n  = SeqIdle;
      end
      default: state_n = SeqIdle;
    endcase
  end

  assign busy           = (state_q != SeqIdle);
  assign redirect_pc    = rpc_q;
  assign privilege_mode = priv_q;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed bench for csr_trap_sequencer: trap entry, delegation, interrupts,
// returns, illegal returns and reset abort, with hand-computed expectations.
module tb_csr_trap_sequencer;
  import csr_pkg::*;

  logic            clock;
  logic            reset;
  logic            instr_valid;
  csr_op_t         csr_op;
  logic [63:0]     pc;
  logic [31:0]     instr;
  logic [63:0]     mstatus, mie, mip, mideleg, medeleg, mtvec, stvec, mepc, sepc;
  logic            csr_we;
  csr_addr_t       csr_waddr;
  logic [63:0]     csr_wdata;
  logic            busy;
  logic            redirect;
  logic [63:0]     redirect_pc;
  privilege_mode_t privilege_mode;

  int errors = 0;
  int checks = 0;

  csr_trap_sequencer #(.XLEN(64)) dut (
    .clock          (clock),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .csr_op         (csr_op),
    .pc             (pc),
    .instr          (instr),
    .mstatus        (mstatus),
    .mie            (mie),
    .mip            (mip),
    .mideleg        (mideleg),
    .medeleg        (medeleg),
    .mtvec          (mtvec),
    .stvec          (stvec),
    .mepc           (mepc),
    .sepc           (sepc),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .busy           (busy),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .privilege_mode (privilege_mode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic defaults();
    instr_valid = 1'b0;
    csr_op      = CsrNone;
    pc          = 64'h0;
    instr       = 32'h0;
    mstatus     = 64'h0;
    mie         = 64'h0;
    mip         = 64'h0;
    mideleg     = 64'h0;
    medeleg     = 64'h0;
    mtvec       = 64'h8000_0100;
    stvec       = 64'h8000_0200;
    mepc        = 64'h8000_0400;
    sepc        = 64'h8000_0500;
  endtask

  // Present one instruction for the accept edge, then corrupt every input so
  // the checks only pass if the sequencer latched what it needed.
  task automatic issue(input csr_op_t op);
    csr_op      = op;
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    csr_op      = CsrEcall;
    pc          = ~pc;
    instr       = ~instr;
    mstatus     = ~mstatus;
    medeleg     = ~medeleg;
    mtvec       = ~mtvec;
    stvec       = ~stvec;
    mepc        = ~mepc;
    sepc        = ~sepc;
  endtask

  task automatic expect_write(input string tag, input logic [11:0] addr, input logic [63:0] data);
    @(negedge clock);
    check_eq({tag, ".we"},   64'(csr_we), 64'd1);
    check_eq({tag, ".addr"}, 64'(csr_waddr), 64'(addr));
    check_eq({tag, ".data"}, csr_wdata, data);
  endtask

  task automatic expect_done(input string tag, input logic [63:0] rpc, input logic [1:0] prv);
    @(negedge clock);
    check_eq({tag, ".redirect"}, 64'(redirect), 64'd1);
    check_eq({tag, ".rpc"},      redirect_pc, rpc);
    check_eq({tag, ".busy_done"}, 64'(busy), 64'd1);
    check_eq({tag, ".we_done"},  64'(csr_we), 64'd0);
    @(negedge clock);
    check_eq({tag, ".priv"},     64'(privilege_mode), 64'(prv));
    check_eq({tag, ".idle"},     64'({busy, redirect}), 64'd0);
  endtask

  task automatic expect_trap(input string tag, input logic s, input logic [63:0] epc,
                             input logic [63:0] cause, input logic [63:0] tval,
                             input logic [63:0] status, input logic [63:0] rpc,
                             input logic [1:0] prv);
    logic [11:0] base;
    base = s ? 12'h100 : 12'h300;
    expect_write({tag, ".epc"},    base + 12'h041, epc);
    expect_write({tag, ".cause"},  base + 12'h042, cause);
    expect_write({tag, ".tval"},   base + 12'h043, tval);
    expect_write({tag, ".status"}, base, status);
    expect_done(tag, rpc, prv);
  endtask

  // Return with mip/mie clear so no interrupt preempts it.
  task automatic do_return(input string tag, input csr_op_t op, input logic [63:0] st,
                           input logic [11:0] addr, input logic [63:0] exp_st,
                           input logic [63:0] rpc, input logic [1:0] prv);
    @(negedge clock);
    defaults();
    mstatus = st;
    issue(op);
    expect_write({tag, ".status"}, addr, exp_st);
    expect_done(tag, rpc, prv);
  endtask

  initial begin
    logic [63:0] vec_pc;
    defaults();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst.we",    64'(csr_we), 64'd0);
    check_eq("rst.waddr", 64'(csr_waddr), 64'h300);
    check_eq("rst.wdata", csr_wdata, 64'h0);
    check_eq("rst.busy",  64'(busy), 64'd0);
    check_eq("rst.redir", 64'(redirect), 64'd0);
    check_eq("rst.rpc",   redirect_pc, 64'h0);
    check_eq("rst.priv",  64'(privilege_mode), 64'd3);
    reset = 1'b0;

    // MRET in Machine, MPP=01 MPIE=1 -> Supervisor
    do_return("mret_m", CsrMret, 64'h880, 12'h300, 64'h88, 64'h8000_0400, 2'b01);
    // SRET in Supervisor, SPP=0 SPIE=1 -> User
    do_return("sret_s", CsrSret, 64'h20, 12'h100, 64'h22, 64'h8000_0500, 2'b00);

    // Ecall from User, not delegated
    @(negedge clock);
    defaults();
    pc = 64'h8000_0010; mstatus = 64'h8;
    issue(CsrEcall);
    expect_trap("ecall_m", 1'b0, 64'h8000_0010, 64'd8, 64'h0, 64'h80, 64'h8000_0100, 2'b11);

    do_return("ret1", CsrMret, 64'h0, 12'h300, 64'h80, 64'h8000_0400, 2'b00);

    // Ecall from User, delegated to Supervisor
    @(negedge clock);
    defaults();
    pc = 64'h8000_0010; mstatus = 64'h2; medeleg = 64'h100;
    issue(CsrEcall);
    expect_trap("ecall_s", 1'b1, 64'h8000_0010, 64'd8, 64'h0, 64'h20, 64'h8000_0200, 2'b01);

    do_return("ret2", CsrSret, 64'h0, 12'h100, 64'h20, 64'h8000_0500, 2'b00);

    // Machine timer interrupt from User with vectored mtvec
    @(negedge clock);
    defaults();
    pc = 64'h8000_0050; mstatus = 64'h8; mip = 64'h80; mie = 64'h80; mtvec = 64'h8000_0101;
`ifdef CSR_VECTORED_TRAP_EN
    vec_pc = 64'h8000_011C;
`else
    vec_pc = 64'h8000_0100;
`endif
    issue(CsrNone);
    expect_trap("mti", 1'b0, 64'h8000_0050, 64'h8000_0000_0000_0007, 64'h0, 64'h80, vec_pc, 2'b11);

    do_return("ret3", CsrMret, 64'h0, 12'h300, 64'h80, 64'h8000_0400, 2'b00);

    // MRET from User is an illegal instruction
    @(negedge clock);
    defaults();
    pc = 64'h8000_0020; instr = 32'h3020_0073; mstatus = 64'h8;
    issue(CsrMret);
    expect_trap("ill_mret", 1'b0, 64'h8000_0020, 64'd2, 64'h3020_0073, 64'h80, 64'h8000_0100, 2'b11);

    do_return("ret4", CsrMret, 64'h0, 12'h300, 64'h80, 64'h8000_0400, 2'b00);

    // Ecall beats pending MEI+MTI
    @(negedge clock);
    defaults();
    pc = 64'h8000_0030; mstatus = 64'h8; mip = 64'h880; mie = 64'h880;
    issue(CsrEcall);
    expect_trap("ecall_irq", 1'b0, 64'h8000_0030, 64'd8, 64'h0, 64'h80, 64'h8000_0100, 2'b11);

    // Machine with MIE=0: pending M interrupt not taken
    @(negedge clock);
    defaults();
    mip = 64'h880; mie = 64'h880;
    issue(CsrNone);
    @(negedge clock);
    check_eq("m_mie0.busy", 64'({busy, csr_we}), 64'd0);

    // Machine: delegated interrupts never taken
    @(negedge clock);
    defaults();
    mstatus = 64'ha; mip = 64'h880; mie = 64'h880; mideleg = 64'h880;
    issue(CsrNone);
    @(negedge clock);
    check_eq("m_deleg.busy", 64'({busy, csr_we}), 64'd0);

    // Machine, MIE=1: MEI wins over MTI, MPP records Machine
    @(negedge clock);
    defaults();
    pc = 64'h8000_0060; mstatus = 64'h8; mip = 64'h880; mie = 64'h880;
    issue(CsrNone);
    expect_trap("mei", 1'b0, 64'h8000_0060, 64'h8000_0000_0000_000B, 64'h0, 64'h1880,
                64'h8000_0100, 2'b11);

    do_return("ret5", CsrMret, 64'h0, 12'h300, 64'h80, 64'h8000_0400, 2'b00);

    // Reset during Cause aborts the sequence
    @(negedge clock);
    defaults();
    pc = 64'h8000_0040;
    issue(CsrEcall);
    expect_write("rst_seq.epc",   12'h341, 64'h8000_0040);
    expect_write("rst_seq.cause", 12'h342, 64'd8);
    reset = 1'b1;
    @(negedge clock);
    check_eq("rst_seq.we",   64'(csr_we), 64'd0);
    check_eq("rst_seq.busy", 64'(busy), 64'd0);
    check_eq("rst_seq.priv", 64'(privilege_mode), 64'd3);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_seq.after", 64'({busy, csr_we, redirect}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csr_trap_sequencer.md
# csr_trap_sequencer

Multi-cycle controller that owns the single CSR write port and the hart privilege register, and sequences every trap entry (exception or interrupt) and trap return (MRET/SRET) into the CSR file. Sits between decode/execute, which presents one retiring instruction with its `csr_op_t`, and the CSR register file, which it drives one CSR write per cycle. It issues a one-cycle redirect (new PC, new privilege) to fetch when the sequence ends.

## Interface
- `XLEN`, default 64: register and PC width.
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: instruction boundary; `csr_op`, `pc`, `instr` valid.
- `csr_op` in `csr_op_t`: operation of the current instruction.
- `pc` in XLEN: PC of the current instruction.
- `instr` in 32: raw instruction bits, used for tval.
- `mstatus`, `mie`, `mip`, `mideleg`, `medeleg`, `mtvec`, `stvec`, `mepc`, `sepc` in XLEN each: current CSR values.
- `csr_we` out 1: CSR write strobe.
- `csr_waddr` out `csr_addr_t`: CSR write address.
- `csr_wdata` out XLEN: CSR write data.
- `busy` out 1: sequence in progress; the core stalls.
- `redirect` out 1: one-cycle pulse; `redirect_pc` and `privilege_mode` take effect.
- `redirect_pc` out XLEN: target PC.
- `privilege_mode` out `privilege_mode_t`: current privilege.

## Operation
- Accept only in Idle with `instr_valid`=1. In other states, inputs are ignored.
- Priority at accept, first match wins:
  - MRET from User or Supervisor, SRET from User: illegal instruction, cause II.
  - `CsrIllegalInstruction`: cause II.
  - `CsrEcall`: cause ECU, ECS or ECM by current privilege.
  - Interrupt.
  - MRET or SRET.
  - Anything else: no action.
- Interrupts:
  - Pending set is `mip & mie`.
  - Fixed order: MEI, MSI, MTI, SEI, SSI, STI.
  - Delegated when the `mideleg` bit is set; delegated interrupts target Supervisor.
  - An M-target interrupt is taken if priv < Machine, or priv = Machine with MIE set.
  - An S-target interrupt is taken if priv = User, or priv = Supervisor with SIE set. It is never taken in Machine.
- Exceptions target Supervisor when the `medeleg[cause]` bit is set and priv ≠ Machine. Otherwise they target Machine.
- Trap entry writes, in order, to the target x = M or S:
  - xepc = `pc`.
  - xcause = code, with bit XLEN-1 set for interrupts.
  - xtval = zero-extended `instr` for II, 0 otherwise.
  - xstatus, written to Mstatus or Sstatus.
- Status updates, computed from `mstatus`:
  - M target: MPIE←MIE, MIE←0, MPP←priv.
  - S target: SPIE←SIE, SIE←0, SPP←priv[0].
- New privilege after trap entry is the target.
- Redirect PC on trap entry: xtvec with bits [1:0] cleared.
- MRET:
  - Writes Mstatus with MIE←MPIE, MPIE←1, MPP←User.
  - New privilege = old MPP. PC = `mepc`.
- SRET:
  - Writes Sstatus with SIE←SPIE, SPIE←1, SPP←0.
  - New privilege = Supervisor if SPP=1, else User. PC = `sepc`.
- Everything is latched at accept: target, cause, epc, tval, status word, redirect PC and new privilege. Later input changes have no effect on the sequence.

## Timing
- States and transitions:
  - Trap: Idle → Epc → Cause → Tval → Status → Done → Idle.
  - Return: Idle → Status → Done → Idle.
- Cycle counts, with accept at cycle 0:
  - Trap: `csr_we` high in cycles 1–4. `redirect` and the new privilege in cycle 5.
  - Return: write in cycle 1, redirect in cycle 2.
- `busy` is high exactly when state ≠ Idle.
- The next accept is possible in the cycle after Done.
- `privilege_mode` updates on the clock edge ending Done. It is visible from cycle 6 (trap) or cycle 3 (return); `redirect_pc` is valid during Done.
- Reset values: state Idle, `csr_we`=0, `csr_waddr`=Mstatus, `csr_wdata`=0, `busy`=0, `redirect`=0, `redirect_pc`=0, `privilege_mode`=Machine.
- Reset in any state aborts to Idle in the next cycle, with no further writes. Partial CSR writes already made stand.

## Configuration
- `CSR_VECTORED_TRAP_EN` defined:
  - xtvec[1:0]=01 with an interrupt: redirect = base + 4×code.
  - Exceptions always go to base.
- Not defined: xtvec mode bits are ignored and every redirect goes to base.

## Structure
- Add to `csr_pkg`:
  - Sequencer state enum.
  - `CauseInterruptBit` = XLEN-1.
  - Interrupt priority order.
  - mstatus bit positions; the `status_t` values are reused.
- Sub-module `csr_irq_select`: combinational. Takes pending, enable, delegation and privilege. Outputs valid, `interrupt_t` code and target privilege.

## Test plan
- Ecall in User, `medeleg`=0, `pc`=0x8000_0010, `mtvec`=0x8000_0100, MIE=1:
  - Required writes: Mepc=0x8000_0010, Mcause=8, Mtval=0, Mstatus with MPP=00, MPIE=1, MIE=0.
  - Cycle 5: redirect to 0x8000_0100, priv Machine.
- Same ecall with `medeleg`[8]=1 and `stvec`=0x8000_0200: Sepc, Scause=8, Stval, Sstatus written (SPP=0), redirect 0x8000_0200, priv Supervisor.
- User mode, `mip`=`mie`=0x80, `mtvec`=0x8000_0101:
  - Mcause=0x8000_0000_0000_0007.
  - Redirect 0x8000_011C with the macro, 0x8000_0100 without.
- MRET in Machine, MPP=01, MPIE=1, `mepc`=0x8000_0400: Mstatus written with MIE=1, MPIE=1, MPP=00; cycle 2 redirect 0x8000_0400; priv Supervisor.
- MRET in User, `instr`=0x3020_0073: II trap with Mcause=2, Mtval=0x3020_0073.
- Ecall while MEI and MTI are pending and enabled: Mcause=ECU, not an interrupt.
- Reset asserted during Cause: `csr_we`=0 the next cycle, Idle, priv Machine.
